fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 imem_req_valid  output  1  SHALL flag a fetch request.
REQ-005 imem_req_ready  input  1  SHALL flag that the memory accepts the request.
REQ-006 imem_req_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-007 imem_rsp_valid  input  1  SHALL flag returned instruction data; it has no backpressure.
REQ-008 imem_rsp_data  input  32  SHALL carry the returned instruction word.
REQ-009 redirect_valid  input  1  SHALL flag a branch, jump or flush redirect from downstream.
REQ-010 redirect_pc  input  32  SHALL carry the redirect target.
REQ-011 id_ready  input  1  SHALL flag that the decode stage accepts if_instr this cycle.
REQ-012 if_valid  output  1  SHALL flag that if_instr and if_pc are valid; the output is registered.
REQ-013 if_instr  output  32  SHALL carry the fetched instruction to decode; the output is registered.
REQ-014 if_pc  output  32  SHALL carry the address of if_instr; the output is registered.
REQ-015 misaligned_fault  output  1  SHALL pulse when redirect_pc[1:0] is nonzero; the output is registered.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and DROP, with at most one memory request outstanding.
REQ-017 imem_req_valid SHALL be 1 only in REQ, and imem_req_addr SHALL equal the internal pc register.
REQ-018 IDLE SHALL go to REQ on the first clock edge after rst_n rises, and SHALL ignore imem_rsp_valid.
REQ-019 In REQ, an edge with imem_req_ready=1 SHALL move the FSM to WAIT; otherwise it stays in REQ.
REQ-020 In WAIT, when imem_rsp_valid=1 and the output slot is free (if_valid=0, or id_ready=1), the FSM SHALL:
- load if_instr, if_pc and if_valid=1;
- set pc <= pc+4;
- go to REQ.
REQ-021 In WAIT, when imem_rsp_valid=1 and the output slot is occupied and id_ready=0, the FSM SHALL capture the data and pc into a one-entry skid buffer and go to HOLD.
REQ-022 In HOLD, on the edge where id_ready=1, the FSM SHALL move the skid entry to the outputs, set pc <= pc+4 and go to REQ.
REQ-023 A transfer occurs when if_valid=1 and id_ready=1; if_valid SHALL clear after a transfer unless a new instruction is loaded on the same edge.
REQ-024 if_* SHALL stay stable while if_valid=1 and id_ready=0.
REQ-025 redirect_valid SHALL have priority over every other event; on that edge the block SHALL:
- clear if_valid and the skid buffer;
- set pc <= {redirect_pc[31:2],2'b00}.
REQ-026 Next state after a redirect SHALL be:
- DROP if a request is outstanding after the edge (WAIT without rsp_valid, REQ with req_ready, or DROP without rsp_valid);
- REQ otherwise, and any rsp_valid on that edge is discarded.
REQ-027 DROP SHALL discard the next response and then go to REQ; a redirect while in DROP updates pc only.
REQ-028 misaligned_fault SHALL be 1 for exactly the cycle after a redirect with redirect_pc[1:0] != 0.
REQ-029 pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without a fault.
REQ-030 Best-case throughput SHALL be one instruction per 2 cycles; response-to-if_valid latency SHALL be 1 edge.

Reset
REQ-031 While rst_n=0, the block SHALL hold:
- state IDLE, pc=RESET_PC;
- if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0;
- misaligned_fault=0, skid buffer empty, imem_req_valid=0.
REQ-032 Reset asserted mid-operation SHALL abandon any outstanding request without further handshake.

Verification
REQ-033 Reset release with req_ready=1 and the response 1 cycle after accept carrying 0x00500093 -> request to 0x0, then if_valid=1, if_instr=0x00500093, if_pc=0x0, then a request to 0x4.
REQ-034 id_ready=0 for 6 cycles with responses 0x4/0x8 pending -> HOLD entered and no request issued; after id_ready=1, instructions are delivered in order pc 0x4 then 0x8, none lost or duplicated.
REQ-035 Redirect to 0x100 in WAIT, stale response 2 cycles later -> stale data never appears on if_*; next request address is 0x100.
REQ-036 Redirect to 0x200 coincident with rsp_valid -> response discarded; next-cycle request to 0x200 with no DROP visit.
REQ-037 Redirect to 0x102 -> misaligned_fault=1 for one cycle; next request address is 0x100.
REQ-038 rst_n low in WAIT -> all outputs reach their reset values immediately; after release, the first request goes to RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single outstanding memory request, a one-entry skid
// buffer toward decode, and redirect handling that discards in-flight responses.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misaligned_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        if_valid_reg, if_valid_next;
    logic [31:0] if_instr_reg, if_instr_next;
    logic [31:0] if_pc_reg, if_pc_next;
    logic        fault_reg, fault_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic        slot_free;
    logic        outstanding_after;

    assign slot_free = !if_valid_reg || id_ready;

    // A request is still in flight after this edge when the redirect lands on it.
    assign outstanding_after = ((state_reg == WAIT) && !imem_rsp_valid) ||
                               ((state_reg == REQ)  && imem_req_ready)  ||
                               ((state_reg == DROP) && !imem_rsp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            if_valid_reg   <= 1'b0;
            if_instr_reg   <= NOP;
            if_pc_reg      <= 32'h0000_0000;
            fault_reg      <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= 32'h0000_0000;
            skid_pc_reg    <= 32'h0000_0000;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            if_valid_reg   <= if_valid_next;
            if_instr_reg   <= if_instr_next;
            if_pc_reg      <= if_pc_next;
            fault_reg      <= fault_next;
            skid_valid_reg <= skid_valid_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        if_valid_next   = if_valid_reg && !id_ready;
        if_instr_next   = if_instr_reg;
        if_pc_next      = if_pc_reg;
        fault_next      = 1'b0;
        skid_valid_next = skid_valid_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;

        if (redirect_valid) begin
            if_valid_next   = 1'b0;
            skid_valid_next = 1'b0;
            pc_next         = {redirect_pc[31:2], 2'b00};
            fault_next      = |redirect_pc[1:0];
            state_next      = outstanding_after ? DROP : REQ;
        end else begin
            case (state_reg)
                IDLE: state_next = REQ;
                REQ: begin
                    if (imem_req_ready) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (slot_free) begin
                            if_valid_next = 1'b1;
                            if_instr_next = imem_rsp_data;
                            if_pc_next    = pc_reg;
                            pc_next       = pc_reg + 32'd4;
                            state_next    = REQ;
                        end else begin
                            skid_valid_next = 1'b1;
                            skid_instr_next = imem_rsp_data;
                            skid_pc_next    = pc_reg;
                            state_next      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (id_ready && skid_valid_reg) begin
                        if_valid_next   = 1'b1;
                        if_instr_next   = skid_instr_reg;
                        if_pc_next      = skid_pc_reg;
                        skid_valid_next = 1'b0;
                        pc_next         = pc_reg + 32'd4;
                        state_next      = REQ;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state_next = REQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign imem_req_valid   = (state_reg == REQ);
    assign imem_req_addr    = pc_reg;
    assign if_valid         = if_valid_reg;
    assign if_instr         = if_instr_reg;
    assign if_pc            = if_pc_reg;
    assign misaligned_fault = fault_reg;

endmodule
